led_arbiter: RTL and testbench

Shares the 7-bit active-low LED bank between three display sources: button counter, PWM brightness readout and idle pattern. Fixed-priority arbiter with a minimum-hold time before preemption and a linger period that freezes the last image after the owner releases. Sits between the display sources and the `led` pins, clocked from `clk_50mhz`, with time measured in slow ticks derived internally.

---
 rtl/led_arbiter_if.sv | 12 +
 rtl/led_arbiter.sv | 74 +++++++
 tb/tb_led_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/led_arbiter_if.sv
// led_arbiter_if: display-source requests and images in, grant and LED bank out.
interface led_arbiter_if;
    logic [2:0] req;
    logic [6:0] data0;
    logic [6:0] data1;
    logic [6:0] data2;
    logic [2:0] gnt;
    logic [6:0] led;
    logic       busy;
    modport master (output req, data0, data1, data2, input gnt, led, busy);
    modport slave (input req, data0, data1, data2, output gnt, led, busy);
endinterface

// File: rtl/led_arbiter.sv
// led_arbiter: fixed-priority owner of the active-low LED bank with tick-based
// minimum hold before preemption and a linger that freezes the last image.
module led_arbiter #(
    parameter int TICK_BITS    = 20,
    parameter int MIN_HOLD     = 8,
    parameter int LINGER_TICKS = 63
) (
    input logic clk_50mhz,
    input logic reset,
    led_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, LINGER} state_t;
    localparam logic [7:0] HOLD = 8'(MIN_HOLD);
    localparam logic [7:0] LT   = 8'(LINGER_TICKS);
    state_t               state;
    logic [TICK_BITS-1:0] tick_cnt;
    logic [1:0]           owner;
    logic [7:0]           hold_cnt;
    logic [7:0]           linger_cnt;
    logic                 tick;
    logic [1:0]           hi;
    logic [6:0]           hi_img;
    logic [6:0]           own_img;
    logic                 own_req;
    logic                 take;
    assign tick    = &tick_cnt;
    assign hi      = bus.req[0] ? 2'd0 : bus.req[1] ? 2'd1 : 2'd2;
    assign hi_img  = hi == 2'd0 ? bus.data0 : hi == 2'd1 ? bus.data1 : bus.data2;
    assign own_img = owner == 2'd0 ? bus.data0 : owner == 2'd1 ? bus.data1 : bus.data2;
    assign own_req = bus.req[owner];
    // Any new ownership (from idle, linger, handoff or preemption) goes through take.
    assign take = |bus.req && (state != GRANT || !own_req || (hi < owner && hold_cnt >= HOLD));
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            tick_cnt   <= '0;
            state      <= IDLE;
            owner      <= 2'd0;
            hold_cnt   <= '0;
            linger_cnt <= '0;
            bus.gnt    <= '0;
            bus.led    <= 7'h7F;
            bus.busy   <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            if (take) begin
                state    <= GRANT;
                owner    <= hi;
                hold_cnt <= '0;
                bus.gnt  <= 3'b001 << hi;
                bus.led  <= ~hi_img;
                bus.busy <= 1'b1;
            end else if (state == GRANT && !own_req) begin
                bus.gnt    <= '0;
                linger_cnt <= '0;
                if (LINGER_TICKS == 0) begin
                    state    <= IDLE;
                    bus.led  <= 7'h7F;
                    bus.busy <= 1'b0;
                end else begin
                    state <= LINGER;
                end
            end else if (state == GRANT) begin
                bus.led <= ~own_img;
                if (tick && ~&hold_cnt) hold_cnt <= hold_cnt + 1'b1;
            end else if (state == LINGER && linger_cnt == LT) begin
                state    <= IDLE;
                bus.led  <= 7'h7F;
                bus.busy <= 1'b0;
            end else if (state == LINGER) begin
                if (tick && ~&linger_cnt) linger_cnt <= linger_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: table-driven scenarios; each cycle's expected outputs go through
// a scoreboard queue and are compared one cycle later against the DUT.
module tb_led_arbiter;
    typedef struct packed {
        logic [7:0] n;
        logic       rst;
        logic [2:0] req;
        logic [6:0] d0;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [2:0] gnt;
        logic [6:0] led;
        logic       busy;
    } step_t;
    typedef struct packed {
        logic [2:0] gnt;
        logic [6:0] led;
        logic       busy;
    } exp_t;
    logic  clk_50mhz = 1'b0;
    logic  reset = 1'b0;
    exp_t  sb[$];
    int    checks = 0;
    int    fails = 0;
    led_arbiter_if bus();
    led_arbiter #(.TICK_BITS(2), .MIN_HOLD(2), .LINGER_TICKS(3)) dut (
        .clk_50mhz(clk_50mhz),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk_50mhz = ~clk_50mhz;
    task automatic apply(input step_t s);
        reset     = s.rst;
        bus.req   = s.req;
        bus.data0 = s.d0;
        bus.data1 = s.d1;
        bus.data2 = s.d2;
    endtask
    task automatic test_reset;
        step_t t [2] = '{
            '{8'd2, 1'b1, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd3, 1'b0, 3'b000, 7'h55, 7'h2A, 7'h7F, 3'b000, 7'h7F, 1'b0}};
        exp_t e;
        foreach (t[i]) for (int k = 0; k < int'(t[i].n); k++) begin
            apply(t[i]);
            sb.push_back('{t[i].gnt, t[i].led, t[i].busy});
            @(posedge clk_50mhz); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.gnt, bus.led, bus.busy} !== e) begin
                fails++;
                $display("FAIL reset[%0d.%0d]: gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         i, k, bus.gnt, bus.led, bus.busy, e.gnt, e.led, e.busy);
            end
        end
    endtask
    task automatic test_single_grant;
        step_t t [5] = '{
            '{8'd1, 1'b1, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd1, 1'b0, 3'b100, 7'h00, 7'h00, 7'h15, 3'b100, 7'h6A, 1'b1},
            '{8'd1, 1'b0, 3'b100, 7'h00, 7'h00, 7'h01, 3'b100, 7'h7E, 1'b1},
            '{8'd1, 1'b0, 3'b000, 7'h00, 7'h00, 7'h15, 3'b000, 7'h7E, 1'b1},
            '{8'd2, 1'b0, 3'b000, 7'h00, 7'h00, 7'h15, 3'b000, 7'h7E, 1'b1}};
        exp_t e;
        foreach (t[i]) for (int k = 0; k < int'(t[i].n); k++) begin
            apply(t[i]);
            sb.push_back('{t[i].gnt, t[i].led, t[i].busy});
            @(posedge clk_50mhz); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.gnt, bus.led, bus.busy} !== e) begin
                fails++;
                $display("FAIL single_grant[%0d.%0d]: gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         i, k, bus.gnt, bus.led, bus.busy, e.gnt, e.led, e.busy);
            end
        end
    endtask
    task automatic test_preempt;
        // Reset clears the tick counter, so ticks land 3 and 7 edges after the grant.
        step_t t [5] = '{
            '{8'd1,  1'b1, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd1,  1'b0, 3'b100, 7'h2A, 7'h00, 7'h15, 3'b100, 7'h6A, 1'b1},
            '{8'd7,  1'b0, 3'b101, 7'h2A, 7'h00, 7'h15, 3'b100, 7'h6A, 1'b1},
            '{8'd1,  1'b0, 3'b101, 7'h2A, 7'h00, 7'h15, 3'b001, 7'h55, 1'b1},
            '{8'd16, 1'b0, 3'b011, 7'h2A, 7'h00, 7'h15, 3'b001, 7'h55, 1'b1}};
        exp_t e;
        foreach (t[i]) for (int k = 0; k < int'(t[i].n); k++) begin
            apply(t[i]);
            sb.push_back('{t[i].gnt, t[i].led, t[i].busy});
            @(posedge clk_50mhz); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.gnt, bus.led, bus.busy} !== e) begin
                fails++;
                $display("FAIL preempt[%0d.%0d]: gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         i, k, bus.gnt, bus.led, bus.busy, e.gnt, e.led, e.busy);
            end
        end
    endtask
    task automatic test_linger;
        step_t t [9] = '{
            '{8'd1,  1'b1, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd1,  1'b0, 3'b010, 7'h00, 7'h7F, 7'h00, 3'b010, 7'h00, 1'b1},
            '{8'd1,  1'b0, 3'b000, 7'h00, 7'h7F, 7'h00, 3'b000, 7'h00, 1'b1},
            '{8'd10, 1'b0, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h00, 1'b1},
            '{8'd2,  1'b0, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd1,  1'b1, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd1,  1'b0, 3'b010, 7'h00, 7'h7F, 7'h00, 3'b010, 7'h00, 1'b1},
            '{8'd3,  1'b0, 3'b000, 7'h00, 7'h7F, 7'h00, 3'b000, 7'h00, 1'b1},
            '{8'd1,  1'b0, 3'b100, 7'h00, 7'h7F, 7'h15, 3'b100, 7'h6A, 1'b1}};
        exp_t e;
        foreach (t[i]) for (int k = 0; k < int'(t[i].n); k++) begin
            apply(t[i]);
            sb.push_back('{t[i].gnt, t[i].led, t[i].busy});
            @(posedge clk_50mhz); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.gnt, bus.led, bus.busy} !== e) begin
                fails++;
                $display("FAIL linger[%0d.%0d]: gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         i, k, bus.gnt, bus.led, bus.busy, e.gnt, e.led, e.busy);
            end
        end
    endtask
    task automatic test_back_to_back;
        step_t t [5] = '{
            '{8'd1, 1'b1, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd2, 1'b0, 3'b001, 7'h2A, 7'h00, 7'h15, 3'b001, 7'h55, 1'b1},
            '{8'd1, 1'b0, 3'b100, 7'h2A, 7'h00, 7'h15, 3'b100, 7'h6A, 1'b1},
            '{8'd1, 1'b0, 3'b010, 7'h2A, 7'h7F, 7'h15, 3'b010, 7'h00, 1'b1},
            '{8'd1, 1'b0, 3'b000, 7'h2A, 7'h7F, 7'h15, 3'b000, 7'h00, 1'b1}};
        exp_t e;
        foreach (t[i]) for (int k = 0; k < int'(t[i].n); k++) begin
            apply(t[i]);
            sb.push_back('{t[i].gnt, t[i].led, t[i].busy});
            @(posedge clk_50mhz); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.gnt, bus.led, bus.busy} !== e) begin
                fails++;
                $display("FAIL back_to_back[%0d.%0d]: gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         i, k, bus.gnt, bus.led, bus.busy, e.gnt, e.led, e.busy);
            end
        end
    endtask
    task automatic test_reset_mid;
        // Reset mid-grant restarts the tick counter, so preemption needs two full ticks again.
        step_t t [9] = '{
            '{8'd1, 1'b1, 3'b000, 7'h00, 7'h00, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd1, 1'b0, 3'b010, 7'h00, 7'h0F, 7'h00, 3'b010, 7'h70, 1'b1},
            '{8'd1, 1'b1, 3'b010, 7'h00, 7'h0F, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd1, 1'b0, 3'b010, 7'h00, 7'h0F, 7'h00, 3'b010, 7'h70, 1'b1},
            '{8'd7, 1'b0, 3'b011, 7'h2A, 7'h0F, 7'h00, 3'b010, 7'h70, 1'b1},
            '{8'd1, 1'b0, 3'b011, 7'h2A, 7'h0F, 7'h00, 3'b001, 7'h55, 1'b1},
            '{8'd1, 1'b0, 3'b000, 7'h2A, 7'h0F, 7'h00, 3'b000, 7'h55, 1'b1},
            '{8'd1, 1'b1, 3'b000, 7'h2A, 7'h0F, 7'h00, 3'b000, 7'h7F, 1'b0},
            '{8'd3, 1'b0, 3'b000, 7'h2A, 7'h0F, 7'h00, 3'b000, 7'h7F, 1'b0}};
        exp_t e;
        foreach (t[i]) for (int k = 0; k < int'(t[i].n); k++) begin
            apply(t[i]);
            sb.push_back('{t[i].gnt, t[i].led, t[i].busy});
            @(posedge clk_50mhz); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.gnt, bus.led, bus.busy} !== e) begin
                fails++;
                $display("FAIL reset_mid[%0d.%0d]: gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         i, k, bus.gnt, bus.led, bus.busy, e.gnt, e.led, e.busy);
            end
        end
    endtask
    initial begin
        bus.req   = 3'b000;
        bus.data0 = 7'h00;
        bus.data1 = 7'h00;
        bus.data2 = 7'h00;
        #2;
        test_reset;
        test_single_grant;
        test_preempt;
        test_linger;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
